// File: rtl/mul_unit_pkg.sv
// rtl/mul_unit_pkg.sv - bus widths, data types and RV32M funct3 constants for mul_unit
package mul_unit_pkg;

  localparam int DATA_BUS_WIDTH        = 32;
  localparam int DOUBLE_DATA_BUS_WIDTH = 64;

  typedef logic [DATA_BUS_WIDTH-1:0]        data_bus_t;
  typedef logic [DOUBLE_DATA_BUS_WIDTH-1:0] double_data_bus_t;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_unit_if.sv
// rtl/mul_unit_if.sv - pipeline and Multiplier-facing signals of mul_unit
interface mul_unit_if;
  import mul_unit_pkg::*;

  logic             flush;
  logic             mul_req;
  logic [2:0]       funct;
  data_bus_t        op1;
  data_bus_t        op2;
  logic             stall_req;
  logic             result_valid;
  data_bus_t        result;
  logic             mul_en;
  data_bus_t        mul_op1;
  data_bus_t        mul_op2;
  double_data_bus_t mul_product;

  // The control stage sits on this side.
  modport slave (
    input  flush, mul_req, funct, op1, op2, mul_product,
    output stall_req, result_valid, result, mul_en, mul_op1, mul_op2
  );

  // The pipeline plus Multiplier environment sits on this side.
  modport master (
    output flush, mul_req, funct, op1, op2, mul_product,
    input  stall_req, result_valid, result, mul_en, mul_op1, mul_op2
  );

endinterface

// File: rtl/mul_unit_fix.sv
// rtl/mul_unit_fix.sv - unsigned correction of the signed product and result word select
module mul_fix
  import mul_unit_pkg::*;
(
  input  double_data_bus_t prod,
  input  data_bus_t        op1,
  input  data_bus_t        op2,
  input  logic [2:0]       funct,
  output data_bus_t        result
);

  data_bus_t hi;
  data_bus_t corr_op1;
  data_bus_t corr_op2;

  assign hi       = prod[63:32];
  // A negative-looking unsigned operand was treated as x - 2^32 by the signed multiplier.
  assign corr_op1 = op2[31] ? op1 : '0;
  assign corr_op2 = op1[31] ? op2 : '0;

  // Pick the low word for MUL, otherwise the high word with the per-class correction.
  always_comb begin
    result = hi;
    case (funct)
      FUNCT3_MUL:    result = prod[31:0];
      FUNCT3_MULH:   result = hi;
      FUNCT3_MULHSU: result = hi + corr_op1;
      FUNCT3_MULHU:  result = hi + corr_op1 + corr_op2;
      default:       result = hi;
    endcase
  end

endmodule

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - RV32M multiply control stage around Multiplier; option MUL_PRODUCT_REUSE_EN
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int MUL_LAT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mul_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT_CYCLES - 1);

  state_e           state_q;
  logic [2:0]       cnt_q;
  data_bus_t        op1_q;
  data_bus_t        op2_q;
  logic [2:0]       funct_q;
  double_data_bus_t prod_q;
  data_bus_t        result_q;
  logic             result_valid_q;
  data_bus_t        fix_result;
  logic             accept;
  logic             abort;
  logic             reuse_hit;
  logic             prod_capture;

  assign abort        = rst | bus.flush;
  assign accept       = (state_q == ST_IDLE) && bus.mul_req && !bus.funct[2] && !abort;
  assign prod_capture = (state_q == ST_WAIT) && (cnt_q == 3'd0);

`ifdef MUL_PRODUCT_REUSE_EN
  data_bus_t last_op1_q;
  data_bus_t last_op2_q;
  logic      last_valid_q;

  assign reuse_hit = last_valid_q && (bus.op1 == last_op1_q) && (bus.op2 == last_op2_q);

  // Remember the operand pair behind prod_q; only reset forgets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_op1_q   <= '0;
      last_op2_q   <= '0;
      last_valid_q <= 1'b0;
    end else if (!bus.flush && prod_capture) begin
      last_op1_q   <= op1_q;
      last_op2_q   <= op2_q;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  mul_fix u_fix (
    .prod   (prod_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .funct  (funct_q),
    .result (fix_result)
  );

  // Control FSM: accept, hold operands through the settle window, correct, then report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      funct_q        <= '0;
      prod_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      funct_q        <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          result_valid_q <= 1'b0;
          if (accept) begin
            op1_q   <= bus.op1;
            op2_q   <= bus.op2;
            funct_q <= bus.funct;
            cnt_q   <= reuse_hit ? 3'd0 : CNT_LOAD;
            state_q <= reuse_hit ? ST_FIX : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            prod_q  <= bus.mul_product;
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_FIX: begin
          result_q       <= fix_result;
          result_valid_q <= 1'b1;
          state_q        <= ST_DONE;
        end
        default: begin
          result_valid_q <= 1'b0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_req    = !abort && (accept || state_q == ST_WAIT || state_q == ST_FIX);
  assign bus.result_valid = result_valid_q && !abort;
  assign bus.result       = result_q;
  assign bus.mul_en       = (state_q == ST_WAIT);
  assign bus.mul_op1      = op1_q;
  assign bus.mul_op2      = op2_q;

endmodule

// File: doc/mul_unit.md
# mul_unit

Sequential control stage wrapped around the combinational `Multiplier` in the EX stage. It captures RV32M multiply requests and drives registered operands into the multiplier. It samples the 64-bit signed product after a fixed settle window, applies unsigned corrections, selects the result word, and raises a stall to the pipeline while busy. Division funct codes are ignored here.

## Interface
- `MUL_LAT_CYCLES`, default 2: cycles the registered operands are held on the multiplier before the product is sampled. Legal range 1..7.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; aborts any operation.
- `mul_req`  in  1  multiply request; held stable by the pipeline while `stall_req`=1.
- `funct`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. 1xx is not accepted.
- `op1`, `op2`  in  `DATA_BUS` (32)  rs1 and rs2 values.
- `stall_req`  out  1  pipeline stall request.
- `result_valid`  out  1  one-cycle pulse; result is present.
- `result`  out  `DATA_BUS`  selected 32-bit result.
- `mul_en`  out  1  enable to `Multiplier`.
- `mul_op1`, `mul_op2`  out  `DATA_BUS`  registered operands to `Multiplier`.
- `mul_product`  in  `DOUBLE_DATA_BUS` (64)  signed product from `Multiplier`.

## Operation
- States: IDLE, WAIT, FIX, DONE.
- **IDLE**
  - Request accepted when `mul_req`=1, `funct[2]`=0 and `flush`=0.
  - On accept: `op1`, `op2` and `funct` are latched, the counter is loaded with `MUL_LAT_CYCLES`-1, and the state goes to WAIT.
- **WAIT**
  - `mul_en`=1; `mul_op1`/`mul_op2` are driven from the latched operands.
  - The counter decrements each cycle.
  - At counter 0, `mul_product` is latched into `prod` and the state goes to FIX.
- **FIX**
  - hi = `prod[63:32]`.
  - MULHSU adds (`op2[31]` ? `op1` : 0).
  - MULHU adds (`op1[31]` ? `op2` : 0) + (`op2[31]` ? `op1` : 0).
  - Sums wrap modulo 2^32.
  - MUL selects `prod[31:0]` for all signedness classes; all other functs select the corrected hi.
  - The selection is registered into `result`; the state goes to DONE.
- **DONE**
  - `result_valid`=1 and `stall_req`=0.
  - The state goes to IDLE unconditionally; `mul_req` is ignored in this cycle.
- **`stall_req`**
  - 1 combinationally in IDLE when a request is accepted.
  - 1 throughout WAIT and FIX.
  - 0 in DONE and in IDLE without an accepted request.
- **Flush and reset**
  - `flush` from any state: next state is IDLE, no `result_valid`, the latched operands are discarded, and `stall_req` drops that same cycle.
  - `flush` together with a request in IDLE: flush wins.
  - `rst` behaves as `flush` and additionally clears every register.
- **`Multiplier` `done` output:** ignored; completion is timed only by the counter.

## Timing
- **Reset values:** `stall_req`=0, `result_valid`=0, `result`=0, `mul_en`=0, `mul_op1`=`mul_op2`=0, state IDLE, counter 0.
- **Latency,** request in cycle T:
  - WAIT spans T+1..T+`MUL_LAT_CYCLES`.
  - FIX is T+`MUL_LAT_CYCLES`+1.
  - `result_valid` is high in T+`MUL_LAT_CYCLES`+2 (T+4 at default).
- **Back-to-back:** the next request is accepted no earlier than T+`MUL_LAT_CYCLES`+3.
- **Multicycle path:** `Multiplier` is a multicycle path of `MUL_LAT_CYCLES` cycles from `mul_op*` to `prod`. `mul_op*` must stay constant throughout WAIT.

## Configuration
- **Macro:** `MUL_PRODUCT_REUSE_EN`.
- **Defined:**
  - `last_op1`, `last_op2` and `last_valid` are kept.
  - `last_valid` is set when `prod` is latched and cleared only by `rst`.
  - An accepted request with `last_valid`=1 and both operands equal to the last pair goes directly IDLE→FIX, reusing `prod`. `result_valid` is then high in T+2.
  - A flush during WAIT leaves `last_*` unchanged.
- **Undefined:**
  - No `last_*` registers exist.
  - Every request takes the full WAIT path.

## Structure
- **`bus.v`:** `DATA_BUS`, `DOUBLE_DATA_BUS`, `DATA_BUS_WIDTH`.
- **`funct.v`:** funct3 constants `FUNCT3_MUL`, `FUNCT3_MULH`, `FUNCT3_MULHSU`, `FUNCT3_MULHU`.
- **State encodings:** localparams inside the module.
- **Sub-module `mul_fix`:** combinational correction and word select (inputs `prod`, `op1`, `op2`, `funct`; output 32-bit). It is instantiated once in FIX.
- **`Multiplier`:** instantiated at EX level alongside this block, not inside it.

## Test plan
- **MUL:** `op1`=7, `op2`=0xFFFFFFFD → `result`=0xFFFFFFEB. `result_valid` in T+4; `stall_req` high T..T+3.
- **MULH:** `op1`=`op2`=0x80000000 → 0x40000000. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- **Unsigned classes:**
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHSU 2×0x80000000 → 0x00000001.
- **Flush:** request MUL 3×5, `flush` in T+1 → no `result_valid`, `stall_req`=0 from T+1, state IDLE. A following MUL 3×5 returns 15 with normal latency.
- **Reuse:** MULH 3×5 (→0) then MUL 3×5 (→15). With `MUL_PRODUCT_REUSE_EN`, the second `result_valid` is at its T+2; without it, at T+4.
- **Reset and non-multiply funct:**
  - `rst` during FIX → all outputs at reset values next cycle, no `result_valid`.
  - `funct`=100 with `mul_req`=1 → never accepted, `stall_req` stays 0.
